// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits WAIT_STATES cycles, commits to a word array, pulses a response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (rejects misaligned addresses and irregular store byte-enables).
module dmem_responder #(
  parameter int ADDR_BITS   = 5,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [31:0]             addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [DEPTH-1:0][31:0]  mem_q, mem_d;

  logic [ADDR_BITS-1:0]    idx;
  logic                    oor;
  logic                    bad;

  assign idx = addr_q[ADDR_BITS+1:2];
  assign oor = |addr_q[31:ADDR_BITS+2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic be_legal;
  always_comb begin
    case (be_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end
  assign bad = oor | (|addr_q[1:0]) | (we_q & ~be_legal);
`else
  // Byte offset carries no meaning when alignment is not enforced.
  logic unused_offset;
  assign unused_offset = ^addr_q[1:0];
  assign bad = oor;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        addr_d  = req_addr;
        be_d    = req_be;
        wdata_d = req_wdata;
        cnt_d   = 4'(WAIT_STATES);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = RESP;
        err_d   = bad;
        rdata_d = '0;
        if (!bad) begin
          if (!we_q) rdata_d = mem_q[idx];
          else
            for (int i = 0; i < 4; i++)
              if (be_q[i]) mem_d[idx][8*i +: 8] = wdata_q[8*i +: 8];
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expectations queued at acceptance, checked on each response pulse.
module tb_dmem_responder;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dmem_responder #(.ADDR_BITS(5), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Drive one request, keep req_valid high through the stall with scrambled fields,
  // and check the response against the expectation queued at acceptance.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int   acc;
    int   n;
    logic ready_ok;
    exp_t e;
    req_we = we; req_addr = addr; req_be = be; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin timeout("accept"); return; end
    @(posedge clk);
    acc = cyc + 1;
    e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    #1;
    chk("acc_edge", 32'(cyc), 32'(acc));
    req_we = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
    ready_ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 30) begin
      if (req_ready) ready_ok = 1'b0;
      @(negedge clk); n++;
    end
    if (!rsp_valid) begin timeout("response"); return; end
    chk("ready_low_in_busy", 32'(ready_ok), 32'd1);
    chk("latency", 32'(cyc - acc), 32'(WS + 1));
    if (exp_q.size() == 0) begin timeout("scoreboard_empty"); return; end
    e = exp_q.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    #2;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err", 32'(rsp_err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic store/load, then byte-lane merge.
    xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    xact(1'b1, 32'h04, 4'hF, 32'h11223344, 32'h0, 1'b0);
    xact(1'b1, 32'h04, 4'b0100, 32'hAABBCCDD, 32'h0, 1'b0);
    xact(1'b0, 32'h04, 4'hF, 32'h0, 32'h11BB3344, 1'b0);

    // Out of range: rejected store, array untouched, rejected load.
    xact(1'b1, 32'h80, 4'hF, 32'h12345678, 32'h0, 1'b1);
    xact(1'b0, 32'h00, 4'h0, 32'h0, 32'h0, 1'b0);
    xact(1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'h0, 1'b1);

    // Top word of the array; zero-enable store is a no-op.
    xact(1'b1, 32'h7C, 4'hF, 32'hA5A5_5A5A, 32'h0, 1'b0);
    xact(1'b0, 32'h7C, 4'h0, 32'h0, 32'hA5A5_5A5A, 1'b0);
    xact(1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    xact(1'b1, 32'h02, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1);
    xact(1'b0, 32'h00, 4'h0, 32'h0, 32'h0, 1'b0);
    xact(1'b1, 32'h0C, 4'b0101, 32'h99887766, 32'h0, 1'b1);
    xact(1'b0, 32'h0C, 4'h0, 32'h0, 32'h0, 1'b0);
`else
    xact(1'b1, 32'h02, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
    xact(1'b0, 32'h00, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    xact(1'b1, 32'h0C, 4'b0101, 32'h99887766, 32'h0, 1'b0);
    xact(1'b0, 32'h0C, 4'h0, 32'h0, 32'h0088_0066, 1'b0);
`endif
    req_valid = 1'b0;
    @(negedge clk);

    // Reset during BUSY of a store drops it and clears the array.
    req_we = 1'b1; req_addr = 32'h08; req_be = 4'hF; req_wdata = 32'h5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst_busy_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xact(1'b0, 32'h08, 4'h0, 32'h0, 32'h0, 1'b0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, 32'h0, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
